// File: rtl/lc3_fetch_stage.sv
// LC-3 fetch stage: owns the PC, issues 1-cycle-latency instruction reads and
// presents instructions to decode through a one-entry skid register.
module lc3_fetch_stage #(
   parameter int            IW       = 16,
   parameter logic [IW-1:0] PC_RESET = IW'(16'h3000)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable_fetch,
   input  logic          stall,
   input  logic          br_taken,
   input  logic [IW-1:0] taddr,
   output logic          imem_rd,
   output logic [IW-1:0] pc,
   input  logic [IW-1:0] imem_rdata,
   output logic [IW-1:0] npc_in,
   output logic [IW-1:0] Imem_dout,
   output logic          enable_decode
);

   logic          issue;
   logic          fresh;
   logic          rd_pend;
   logic          discard;
   logic [IW-1:0] rd_npc;
   logic          skid_valid;
   logic [IW-1:0] skid_data;
   logic [IW-1:0] skid_npc;

   assign issue   = enable_fetch & ~stall & ~br_taken;
   assign imem_rd = reset & issue;

   // Read data on imem_rdata this cycle belongs to an instruction we still want.
   assign fresh = rd_pend & ~discard;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc      <= PC_RESET;
         rd_pend <= 1'b0;
         discard <= 1'b0;
      end else begin
         rd_pend <= issue;
         discard <= br_taken & rd_pend;
         if (br_taken)
            pc <= taddr;
         else if (issue)
            pc <= pc + IW'(1);
      end
   end

   // NOTE: pure data registers are left without reset; their valid bits
   // (rd_pend, skid_valid) are reset, so stale contents are never consumed.
   always_ff @(posedge clock) begin
      if (issue)
         rd_npc <= pc + IW'(1);
      if (stall && !br_taken && fresh) begin
         skid_data <= imem_rdata;
         skid_npc  <= rd_npc;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         skid_valid    <= 1'b0;
         enable_decode <= 1'b0;
         Imem_dout     <= '0;
         npc_in        <= '0;
      end else if (br_taken) begin
         skid_valid    <= 1'b0;
         enable_decode <= 1'b0;
      end else if (stall) begin
         // Outputs hold; the stall cycle issues nothing, so the skid cannot overflow.
         if (fresh)
            skid_valid <= 1'b1;
      end else if (skid_valid) begin
         Imem_dout     <= skid_data;
         npc_in        <= skid_npc;
         enable_decode <= 1'b1;
         skid_valid    <= 1'b0;
      end else if (fresh) begin
         Imem_dout     <= imem_rdata;
         npc_in        <= rd_npc;
         enable_decode <= 1'b1;
      end else begin
         enable_decode <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lc3_fetch_stage.sv
// Self-checking bench for lc3_fetch_stage: directed scenarios followed by random
// enable/stall/redirect traffic, checked against an in-order queue model.
module tb_lc3_fetch_stage;

   logic        clock;
   logic        reset;
   logic        enable_fetch;
   logic        stall;
   logic        br_taken;
   logic [15:0] taddr;

   logic        a_rd, a_ed, b_rd, b_ed;
   logic [15:0] a_pc, a_rdata, a_npc, a_dout;
   logic [15:0] b_pc, b_rdata, b_npc, b_dout;

   int passed = 0;
   int total  = 0;

   // Reference model: addresses fetched but not yet presented, in program order.
   logic [15:0] q[$];
   logic [15:0] m_pc;
   logic [15:0] m_addr;
   logic        m_ev;
   logic        m_seen;

   lc3_fetch_stage dut_a (
      .clock(clock), .reset(reset), .enable_fetch(enable_fetch), .stall(stall),
      .br_taken(br_taken), .taddr(taddr), .imem_rd(a_rd), .pc(a_pc),
      .imem_rdata(a_rdata), .npc_in(a_npc), .Imem_dout(a_dout), .enable_decode(a_ed)
   );

   lc3_fetch_stage #(.PC_RESET(16'hFFFE)) dut_b (
      .clock(clock), .reset(reset), .enable_fetch(enable_fetch), .stall(stall),
      .br_taken(br_taken), .taddr(taddr), .imem_rd(b_rd), .pc(b_pc),
      .imem_rdata(b_rdata), .npc_in(b_npc), .Imem_dout(b_dout), .enable_decode(b_ed)
   );

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a ^ 16'hA5A5;
   endfunction

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Instruction memories: data valid the cycle after a read, garbage otherwise.
   always @(posedge clock) a_rdata <= a_rd ? mem_word(a_pc) : 16'($urandom);
   always @(posedge clock) b_rdata <= b_rd ? mem_word(b_pc) : 16'($urandom);

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset(input logic [15:0] start);
      q.delete();
      m_pc   = start;
      m_addr = 16'h0;
      m_ev   = 1'b0;
      m_seen = 1'b0;
   endtask

   // One clock edge of the model. Popping before pushing means a read issued
   // in this cycle can only be presented after the following edge.
   task automatic model_step(input logic ef, input logic st, input logic br, input logic [15:0] ta);
      if (br) begin
         q.delete();
         m_ev = 1'b0;
      end else if (!st) begin
         if (q.size() != 0) begin
            m_addr = q.pop_front();
            m_ev   = 1'b1;
            m_seen = 1'b1;
         end else begin
            m_ev = 1'b0;
         end
      end
      if (br)
         m_pc = ta;
      else if (ef && !st) begin
         q.push_back(m_pc);
         m_pc = m_pc + 16'h1;
      end
   endtask

   // Called at a negedge: drive inputs, check combinational/registered fetch
   // outputs, take one edge, then check the presented instruction.
   task automatic cyc(input logic ef, input logic st, input logic br, input logic [15:0] ta);
      enable_fetch = ef;
      stall        = st;
      br_taken     = br;
      taddr        = ta;
      #1;
      check("imem_rd", {15'h0, a_rd}, {15'h0, ef & ~st & ~br});
      check("pc", a_pc, m_pc);
      @(posedge clock);
      model_step(ef, st, br, ta);
      @(negedge clock);
      check("enable_decode", {15'h0, a_ed}, {15'h0, m_ev});
      check("Imem_dout", a_dout, m_seen ? mem_word(m_addr) : 16'h0);
      check("npc_in", a_npc, m_seen ? m_addr + 16'h1 : 16'h0);
   endtask

   initial begin
      logic ef, st, br, prev_br;

      reset        = 1'b0;
      enable_fetch = 1'b1;
      stall        = 1'b0;
      br_taken     = 1'b0;
      taddr        = 16'h0;
      model_reset(16'h3000);
      repeat (2) @(negedge clock);
      check("rst_imem_rd", {15'h0, a_rd}, 16'h0);
      check("rst_pc", a_pc, 16'h3000);
      check("rst_enable_decode", {15'h0, a_ed}, 16'h0);
      check("rst_Imem_dout", a_dout, 16'h0);
      check("rst_npc_in", a_npc, 16'h0);

      reset = 1'b1;
      #1;
      check("b_first_pc", b_pc, 16'hFFFE);
      check("first_imem_rd", {15'h0, a_rd}, 16'h1);
      #1;
      @(negedge clock);
      // The first cycle after release was consumed above; account for it.
      model_step(1'b1, 1'b0, 1'b0, 16'h0);

      // Cycle 2 onward; after each call the values shown are the next cycle's.
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      check("first_ed", {15'h0, a_ed}, 16'h1);
      check("first_dout", a_dout, 16'h95A5);
      check("first_npc", a_npc, 16'h3001);
      check("b_wrap_pc", b_pc, 16'h0000);
      check("b_npc_ffff", b_npc, 16'hFFFF);
      check("b_dout_fffe", b_dout, 16'h5A5B);
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      check("second_npc", a_npc, 16'h3002);
      check("b_npc_0000", b_npc, 16'h0000);
      check("b_dout_ffff", b_dout, 16'h5A5A);
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      check("b_npc_0001", b_npc, 16'h0001);
      check("b_dout_0000", b_dout, 16'hA5A5);
      cyc(1'b1, 1'b0, 1'b0, 16'h0);

      // Stall for 3 cycles while the read of 3004 is in flight.
      repeat (3) begin
         cyc(1'b1, 1'b1, 1'b0, 16'h0);
         check("stall_pc", a_pc, 16'h3005);
         check("stall_hold_npc", a_npc, 16'h3004);
         check("stall_hold_dout", a_dout, 16'h95A6);
      end
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      check("skid_ed", {15'h0, a_ed}, 16'h1);
      check("skid_npc", a_npc, 16'h3005);
      check("skid_dout", a_dout, 16'h95A1);
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      check("after_skid_npc", a_npc, 16'h3006);
      cyc(1'b1, 1'b0, 1'b0, 16'h0);

      // Redirect while 3007 is in flight.
      cyc(1'b1, 1'b0, 1'b1, 16'h4000);
      check("br_bubble1", {15'h0, a_ed}, 16'h0);
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      check("br_bubble2", {15'h0, a_ed}, 16'h0);
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      check("br_target_ed", {15'h0, a_ed}, 16'h1);
      check("br_target_npc", a_npc, 16'h4001);
      check("br_target_dout", a_dout, 16'hE5A5);

      // Redirect coincident with stall while the skid holds data.
      cyc(1'b1, 1'b1, 1'b0, 16'h0);
      cyc(1'b1, 1'b1, 1'b1, 16'h5000);
      check("brst_ed", {15'h0, a_ed}, 16'h0);
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      check("brst_bubble", {15'h0, a_ed}, 16'h0);
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      check("brst_target_npc", a_npc, 16'h5001);
      check("brst_target_dout", a_dout, 16'hF5A5);

      // Asynchronous reset mid-stall with the skid full.
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      cyc(1'b1, 1'b1, 1'b0, 16'h0);
      #2 reset = 1'b0;
      #1;
      check("arst_ed", {15'h0, a_ed}, 16'h0);
      check("arst_dout", a_dout, 16'h0);
      check("arst_npc", a_npc, 16'h0);
      check("arst_pc", a_pc, 16'h3000);
      check("arst_imem_rd", {15'h0, a_rd}, 16'h0);
      model_reset(16'h3000);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      check("arst_no_stale", {15'h0, a_ed}, 16'h0);
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      check("arst_restart_npc", a_npc, 16'h3001);

      // Random traffic; redirects are single-cycle pulses.
      prev_br = 1'b0;
      for (int i = 0; i < 400; i++) begin
         ef = ($urandom_range(0, 3) != 0);
         st = ($urandom_range(0, 3) == 0);
         br = !prev_br && ($urandom_range(0, 11) == 0);
         cyc(ef, st, br, 16'($urandom));
         prev_br = br;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
